// File: rtl/sha_hasher_pipe_if.sv
// rtl/sha_hasher_pipe_if.sv - work-in / result-out bundle of the double SHA-256 nonce sweeper
interface sha_hasher_pipe_if;
    logic         write_en;
    logic [255:0] digest_intial;
    logic [255:0] digest_in;
    logic [31:0]  merkle_in;
    logic [31:0]  time_in;
    logic [31:0]  target_in;
    logic [31:0]  nonce_in;
    logic         valid_out;
    logic [31:0]  time_out;
    logic [31:0]  nonce_out;
    logic [255:0] result_out;

    modport master (
        output write_en, digest_intial, digest_in, merkle_in, time_in, target_in, nonce_in,
        input  valid_out, time_out, nonce_out, result_out
    );

    modport slave (
        input  write_en, digest_intial, digest_in, merkle_in, time_in, target_in, nonce_in,
        output valid_out, time_out, nonce_out, result_out
    );
endinterface

// File: rtl/sha_hasher_pipe.sv
// rtl/sha_hasher_pipe.sv - fully pipelined double SHA-256 nonce sweeper, one hash per clock
// Optional compact-target compare on valid_out when TARGET_CHECK_EN is defined.
module sha_hasher_pipe (
    input  logic             CLK,
    input  logic             RST,
    sha_hasher_pipe_if.slave bus
);
    // Stage 0 loads, 1..63 hash-1 rounds, 64 feed-forward/handoff, 65..128 hash-2 rounds, 129 feed-forward
    localparam int NS = 130;
    localparam int H2 = 65;

    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    function automatic logic [31:0] big_s0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_s1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] sml_s0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] sml_s1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

    function automatic logic [255:0] sha_round(input logic [255:0] s, input logic [31:0] k,
                                               input logic [31:0] w);
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        {a, b, c, d, e, f, g, h} = s;
        t1 = h + big_s1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = big_s0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Window holds the next 16 schedule words, oldest (next round's W) in the MSBs
    function automatic logic [511:0] sched_shift(input logic [511:0] wn);
        logic [31:0] nw;
        nw = sml_s1(wn[63:32]) + wn[223:192] + sml_s0(wn[479:448]) + wn[511:480];
        return {wn[479:0], nw};
    endfunction

    function automatic logic [255:0] add8(input logic [255:0] x, input logic [255:0] y);
        return {x[255:224] + y[255:224], x[223:192] + y[223:192], x[191:160] + y[191:160],
                x[159:128] + y[159:128], x[127:96]  + y[127:96],  x[95:64]   + y[95:64],
                x[63:32]   + y[63:32],   x[31:0]    + y[31:0]};
    endfunction

    logic [255:0] mid_q, mid_d, din_q, din_d;
    logic [31:0]  merkle_q, merkle_d, target_q, target_d;
    logic [31:0]  time_q, time_d, nonce_q, nonce_d;

    logic [255:0] st_q [NS];
    logic [255:0] st_d [NS];
    logic [511:0] wn_q [NS];
    logic [511:0] wn_d [NS];
    logic [31:0]  tm_q [NS];
    logic [31:0]  tm_d [NS];
    logic [31:0]  nc_q [NS];
    logic [31:0]  nc_d [NS];
    logic [NS-1:0] vld_q, vld_d;

    logic [255:0] result_q, result_d;
    logic [31:0]  time_out_q, time_out_d, nonce_out_q, nonce_out_d;
    logic         valid_out_q, valid_out_d;
    logic         hit;

    // Work registers and counters follow RST as a load strobe rather than being cleared
    always_comb begin
        mid_d    = mid_q;
        din_d    = din_q;
        merkle_d = merkle_q;
        target_d = target_q;
        time_d   = time_q;
        nonce_d  = nonce_q;
        if (!RST) begin
            if (bus.write_en) begin
                mid_d    = bus.digest_intial;
                din_d    = bus.digest_in;
                merkle_d = bus.merkle_in;
                target_d = bus.target_in;
            end
            time_d  = bus.time_in;
            nonce_d = bus.nonce_in;
        end else begin
            nonce_d = nonce_q + 32'd1;
            if (nonce_q == 32'hFFFF_FFFF) time_d = time_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        mid_q    <= mid_d;
        din_q    <= din_d;
        merkle_q <= merkle_d;
        target_q <= target_d;
        time_q   <= time_d;
        nonce_q  <= nonce_d;
    end

    for (genvar g = 0; g < NS; g++) begin : g_stage
        if (g == 0) begin : g_load
            assign st_d[g] = din_q;
            assign wn_d[g] = {time_q, target_q, nonce_q, 32'h8000_0000, 320'd0, 32'h0000_0280,
                              sml_s0(time_q) + merkle_q};
            assign tm_d[g] = time_q;
            assign nc_d[g] = nonce_q;
        end else begin : g_pipe
            assign tm_d[g] = tm_q[g-1];
            assign nc_d[g] = nc_q[g-1];
            if (g < 64) begin : g_h1
                assign st_d[g] = sha_round(st_q[g-1], K_TAB[g], wn_q[g-1][511:480]);
                assign wn_d[g] = sched_shift(wn_q[g-1]);
            end else if (g == 64) begin : g_handoff
                assign st_d[g] = IV;
                assign wn_d[g] = {add8(st_q[g-1], mid_q), 32'h8000_0000, 192'd0, 32'h0000_0100};
            end else if (g < NS - 1) begin : g_h2
                assign st_d[g] = sha_round(st_q[g-1], K_TAB[g-H2], wn_q[g-1][511:480]);
                assign wn_d[g] = sched_shift(wn_q[g-1]);
            end else begin : g_ff
                assign st_d[g] = add8(st_q[g-1], IV);
                assign wn_d[g] = '0;
            end
        end
    end

    always_ff @(posedge CLK) begin
        st_q <= st_d;
        wn_q <= wn_d;
        tm_q <= tm_d;
        nc_q <= nc_d;
    end

`ifdef TARGET_CHECK_EN
    function automatic logic [255:0] bswap256(input logic [255:0] x);
        logic [255:0] r;
        for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
        return r;
    endfunction

    function automatic logic [255:0] expand_target(input logic [31:0] t);
        logic [31:0]  nbits;
        logic [255:0] m;
        nbits = {t[7:0], t[15:8], t[23:16], t[31:24]};
        m     = {232'd0, nbits[23:0]};
        if (nbits[31:24] >= 8'd3) return m << {nbits[31:24] - 8'd3, 3'b000};
        return m >> {8'd3 - nbits[31:24], 3'b000};
    endfunction

    logic [255:0] target_exp_q, target_exp_d;

    always_comb target_exp_d = expand_target(target_q);

    always_ff @(posedge CLK) target_exp_q <= target_exp_d;

    // Digest is compared as the little-endian 256-bit number Bitcoin uses
    assign hit = (bswap256(st_q[NS-1]) <= target_exp_q);
`else
    assign hit = 1'b1;
`endif

    always_comb begin
        vld_d       = {vld_q[NS-2:0], 1'b1};
        result_d    = result_q;
        time_out_d  = time_out_q;
        nonce_out_d = nonce_out_q;
        valid_out_d = 1'b0;
        if (vld_q[NS-1]) begin
            result_d    = st_q[NS-1];
            time_out_d  = tm_q[NS-1];
            nonce_out_d = nc_q[NS-1];
            valid_out_d = hit;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            vld_q       <= '0;
            result_q    <= '0;
            time_out_q  <= '0;
            nonce_out_q <= '0;
            valid_out_q <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            result_q    <= result_d;
            time_out_q  <= time_out_d;
            nonce_out_q <= nonce_out_d;
            valid_out_q <= valid_out_d;
        end
    end

    assign bus.valid_out  = valid_out_q;
    assign bus.time_out   = time_out_q;
    assign bus.nonce_out  = nonce_out_q;
    assign bus.result_out = result_q;
endmodule

// File: tb/tb_sha_hasher_pipe.sv
// tb/tb_sha_hasher_pipe.sv - directed self-checking bench for sha_hasher_pipe
module tb_sha_hasher_pipe;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

`ifdef TARGET_CHECK_EN
    localparam bit TC = 1'b1;
`else
    localparam bit TC = 1'b0;
`endif

    localparam logic [255:0] MID  = 256'hF59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771;
    localparam logic [255:0] DIN  = 256'hF7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776;
    localparam logic [255:0] H1   = 256'hD113D3BB65EAEED1EBA29A6E06640A8CFD2394C1672229D878D8CEACD8C824A2;
    localparam logic [255:0] R131 = 256'h4FC234738E7F3AC09F4432A23EAB1E707578A6310F0EB320515D61001CB18E75;
    localparam logic [255:0] R132 = 256'hCCA2649D234850E0FD84EDB32B06AE3E415E85F5D19A59622B91F8607B948287;
    localparam logic [255:0] R139 = 256'h5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000;

    sha_hasher_pipe_if bus ();

    sha_hasher_pipe dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.write_en      = 1'b1;
        bus.digest_intial = MID;
        bus.digest_in     = DIN;
        bus.merkle_in     = 32'h252db801;
        bus.target_in     = 32'h6461011a;
        bus.time_in       = 32'hAAAAAAA1;
        bus.nonce_in      = 32'hFFFFFFF0;

        // reset state and counter load
        step(2);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_result", bus.result_out, 0);
        chk("rst_time_out", bus.time_out, 0);
        chk("rst_nonce_out", bus.nonce_out, 0);
        chk("load_nonce", dut.nonce_q, 32'hFFFFFFF0);
        chk("load_time", dut.time_q, 32'hAAAAAAA1);

        // counter rollover
        rst_n = 1'b1;
        step(16);
        chk("wrap_nonce16", dut.nonce_q, 32'h00000000);
        chk("wrap_time16", dut.time_q, 32'hAAAAAAA2);
        step(1);
        chk("wrap_nonce17", dut.nonce_q, 32'h00000001);
        chk("wrap_time17", dut.time_q, 32'hAAAAAAA2);
        step(129);
        chk("roll_nonce_e146", bus.nonce_out, 32'hFFFFFFFF);
        chk("roll_time_e146", bus.time_out, 32'hAAAAAAA1);
        step(1);
        chk("roll_nonce_e147", bus.nonce_out, 32'h00000000);
        chk("roll_time_e147", bus.time_out, 32'hAAAAAAA2);

        // restart with the real header
        #2 rst_n = 1'b0;
        #1;
        chk("async_clr_valid", bus.valid_out, 0);
        chk("async_clr_result", bus.result_out, 0);
        bus.time_in  = 32'h130dae51;
        bus.nonce_in = 32'h3aeb9bb0;
        step(2);
        rst_n = 1'b1;

        step(64);
        chk("h1_valid_e64", dut.vld_q[64], 0);
        step(1);
        chk("h1_valid_e65", dut.vld_q[64], 1);
        chk("h1_digest_e65", dut.wn_q[64][511:256], H1);

        step(65);
        chk("valid_e130", bus.valid_out, 0);
        step(1);
        chk("valid_e131", bus.valid_out, TC ? 0 : 1);
        chk("result_e131", bus.result_out, R131);
        chk("nonce_e131", bus.nonce_out, 32'h3aeb9bb0);
        chk("time_e131", bus.time_out, 32'h130dae51);
        step(1);
        chk("valid_e132", bus.valid_out, TC ? 0 : 1);
        chk("result_e132", bus.result_out, R132);
        chk("nonce_e132", bus.nonce_out, 32'h3aeb9bb1);
        for (int e = 133; e <= 138; e++) begin
            step(1);
            chk($sformatf("valid_e%0d", e), bus.valid_out, TC ? 0 : 1);
        end
        step(1);
        chk("valid_e139", bus.valid_out, 1);
        chk("result_e139", bus.result_out, R139);
        chk("time_e139", bus.time_out, 32'h130dae51);
        chk("nonce_e139", bus.nonce_out, 32'h3aeb9bb8);

        // reset mid-run
        step(3);
        #3 rst_n = 1'b0;
        #1;
        chk("midrun_valid", bus.valid_out, 0);
        chk("midrun_result", bus.result_out, 0);
        chk("midrun_nonce_out", bus.nonce_out, 0);
        step(2);
        rst_n = 1'b1;
        for (int e = 1; e <= 130; e++) begin
            step(1);
            chk($sformatf("no_early_valid_e%0d", e), bus.valid_out, 0);
        end
        step(1);
        chk("rerun_valid_e131", bus.valid_out, TC ? 0 : 1);
        chk("rerun_result_e131", bus.result_out, R131);
        chk("rerun_nonce_e131", bus.nonce_out, 32'h3aeb9bb0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sha_hasher_pipe.md
Name: sha_hasher_pipe

Overview:
- Fully pipelined Bitcoin double-SHA-256 nonce search engine.
- Takes the precomputed midstate of header block 1 plus the 16 tail bytes of the header (merkle tail, time, bits, nonce).
- Sweeps nonce/time every clock and emits one double hash per clock.
- Sits between the work-loader registers and the result/target-check logic of the miner.

Parameters:
- none (widths fixed by SHA-256)

Ports:
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous active-low reset; 0 = reset/load, 1 = run
- write_en  in  1  load-enable for the input work registers; tie 1 in normal use
- digest_intial  in  256  block-1 midstate H0..H7 ({H0,...,H7}, H0 in MSBs); added after round 63 of hash 1
- digest_in  in  256  working state a..h after round 0 of block 2 (round 0 precomputed, since W0 is constant)
- merkle_in  in  32  header word W0 of block 2
- time_in  in  32  header time word, initial value
- target_in  in  32  header bits word, byte-swapped compact target (0x6461011a = nBits 0x1a016164)
- nonce_in  in  32  initial nonce
- valid_out  out  1  result_out/time_out/nonce_out carry a valid hash
- time_out  out  32  time word that produced result_out
- nonce_out  out  32  nonce that produced result_out
- result_out  out  256  final digest {H0,...,H7} of the second SHA-256, no byte swap

Behaviour:
Reset and load:
- While RST=0, every clock loads the work registers (if write_en) and the counters: time counter <= time_in, nonce counter <= nonce_in.
- While RST=0, all pipeline valid bits, valid_out, time_out, nonce_out and result_out are held at 0.
- Asserting reset mid-run asynchronously clears all of these; no partial results emerge afterwards.

Counters:
- On each rising edge with RST=1: nonce <= nonce+1.
- When nonce wraps FFFFFFFF->00000000 on an edge, time <= time+1 on the same edge.

Hash 1 message:
- W0=merkle_in, W1=time counter, W2=target_in, W3=nonce counter, W4=80000000, W5..W14=0, W15=00000280.
- Rounds 1..63 are pipelined one per stage, starting from digest_in.
- Feed-forward: add digest_intial word-wise, modulo 2^32.

Hash 2:
- W0..W7 = hash-1 digest, W8=80000000, W9..W14=0, W15=00000100.
- Standard IV; 64 pipelined rounds plus feed-forward.

Message schedule and pipelining:
- Message-schedule words travel with their stage, so a new input is accepted every clock.
- Time and nonce are delayed in a shift line parallel to the pipeline, giving exact rollback.

Latency:
- The counter values present before rising edge k (edge 1 = first edge after RST rises) produce outputs after edge k+130.
- Hash-1 digest is internally valid after edge k+64.
- valid_out first rises after edge 131 and stays 1 every cycle thereafter while RST=1.

Width rules: all additions are modulo 2^32.

Optional Feature:
- Macro TARGET_CHECK_EN.
- Defined:
  - target_in is expanded: byte-swap to nBits, exponent e=nBits[31:24], mantissa m=nBits[23:0], target = m << 8*(e-3), 256 bits.
  - Expansion is registered once after load.
  - valid_out=1 only when the pipeline output is valid AND byte-reversed(result_out) <= target.
  - result_out/time_out/nonce_out still update every cycle.
- Undefined: valid_out is the pure pipeline-valid flag and no target logic is built.

Test Plan:
1. Counter rollover: RST=0 with time_in=AAAAAAA1, nonce_in=FFFFFFF0, then RST=1.
   - Counters hold AAAAAAA1/FFFFFFF0 before edge 1.
   - After 17 edges: nonce=00000001, time=AAAAAAA2.
2. Hash-1 check: digest_intial=F59007B57A2E5616B8F47922F4A62AA5F6F596588185BBAEFA09E7763BC75771, digest_in=F7A528B9F59007B57A2E5616B8F47922F2C1816DF6F596588185BBAEFA09E776, merkle=252db801, time=130dae51, target_in=6461011a, nonce=3aeb9bb0.
   - Internal hash-1 valid first after edge 65, digest D113D3BB65EAEED1EBA29A6E06640A8CFD2394C1672229D878D8CEACD8C824A2.
   - Internal hash-1 valid is not set after edge 64.
3. Same stimulus, final output:
   - valid_out=0 after edge 130, 1 after edge 131.
   - After edge 131: result_out=4FC234738E7F3AC09F4432A23EAB1E707578A6310F0EB320515D61001CB18E75.
   - After edge 132: result_out=CCA2649D234850E0FD84EDB32B06AE3E415E85F5D19A59622B91F8607B948287.
4. Solution nonce, same stimulus:
   - After edge 139: result_out=5C8AD782C007CC563F8DB735180B35DAB8C983D172B57E2C2701000000000000, time_out=130dae51, nonce_out=3aeb9bb8.
   - With TARGET_CHECK_EN: valid_out=1 only at this edge within edges 131..139.
5. Reset mid-run: drop RST during streaming.
   - valid_out and result_out go to 0 immediately.
   - After release, no valid_out until 131 edges later.
